// File: rtl/uart_tx_if.sv
// Byte handshake between the bus-side producer and the UART transmitter.
interface uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// Oversampled UART transmitter: start, 8 data bits MSB-first, stop.
// Build option: UART_TX_STOP2_EN adds a second stop bit (STOP2 state).
module uart_tx #(
  parameter int Oversample = 16
) (
  input  logic      clk,
  input  logic      nReset,
  uart_tx_if.slave  bus,
  output logic      out_o,
  output logic      busy_o,
  output logic      done_o
);
  localparam int CW = $clog2(Oversample);
  localparam logic [CW-1:0] RELOAD = CW'(Oversample - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

`ifdef UART_TX_STOP2_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, STOP2} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sbuf_q, sbuf_d;
  logic          out_q, out_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= RELOAD;
      bit_q   <= '0;
      sbuf_q  <= '0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sbuf_q  <= sbuf_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - ONE;
    bit_d   = bit_q;
    sbuf_d  = sbuf_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b1;
        cnt_d = RELOAD;
        if (bus.valid) begin
          sbuf_d  = bus.data;
          bit_d   = '0;
          out_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          out_d   = sbuf_q[7];
          sbuf_d  = {sbuf_q[6:0], 1'b0};
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            out_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d  = bit_q + 3'd1;
            out_d  = sbuf_q[7];
            sbuf_d = {sbuf_q[6:0], 1'b0};
          end
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
`ifdef UART_TX_STOP2_EN
          state_d = STOP2;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef UART_TX_STOP2_EN
      STOP2: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = RELOAD;
        out_d   = 1'b1;
      end
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign out_o     = out_q;
  assign done_o    = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx against a frame-position reference model.
module tb_uart_tx;
  localparam int OS = 16;
`ifdef UART_TX_STOP2_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * OS;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic out_o, busy_o, done_o;
  uart_tx_if bus();

  uart_tx #(.Oversample(OS)) dut (
    .clk(clk), .nReset(nReset), .bus(bus),
    .out_o(out_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  longint cyc = 0;
  bit m_act = 0, m_done = 0;
  int m_pos = 0;
  logic [7:0] m_byte = '0;
  longint done_t[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Line level for position p within a frame: bit index p/OS
  function automatic logic m_line();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_pos / OS;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[8-idx];
    return 1'b1;
  endfunction

  task automatic check_outs(string tag);
    chk({tag, ".out"},   32'(out_o),     32'(m_line()));
    chk({tag, ".ready"}, 32'(bus.ready), 32'(!m_act));
    chk({tag, ".busy"},  32'(busy_o),    32'(m_act));
    chk({tag, ".done"},  32'(done_o),    32'(m_done));
  endtask

  task automatic step(string tag);
    m_done = 0;
    if (!nReset) begin
      m_act = 0;
    end else if (!m_act) begin
      if (bus.valid) begin
        m_act = 1; m_pos = 0; m_byte = bus.data;
      end
    end else begin
      m_pos++;
      if (m_pos == FL) begin
        m_act = 0; m_done = 1;
        done_t.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outs(tag);
  endtask

  task automatic send(logic [7:0] b, string tag);
    bus.data = b; bus.valid = 1'b1;
    step(tag);
    bus.valid = 1'b0;
  endtask

  initial begin
    bus.data = '0; bus.valid = 1'b0;
    #12;
    check_outs("rst");
    nReset = 1'b1;
    for (int i = 0; i < 100; i++) step("idle");

    // single byte 0xA5, done exactly FL cycles after handshake
    done_t.delete();
    send(8'hA5, "a5");
    for (int i = 0; i < FL + 4; i++) step("a5");
    chk("a5.ndone", 32'(done_t.size()), 32'd1);
    if (done_t.size() == 1) chk("a5.dlat", 32'(done_t[0] - (cyc - FL - 4)), 32'(FL));

    // back-to-back with valid held: gap between done pulses is FL+1
    done_t.delete();
    bus.data = 8'h00; bus.valid = 1'b1;
    step("b2b");
    bus.data = 8'hFF;
    for (int i = 0; i < FL + 1; i++) step("b2b");
    bus.valid = 1'b0;
    for (int i = 0; i < FL + 4; i++) step("b2b");
    chk("b2b.ndone", 32'(done_t.size()), 32'd2);
    if (done_t.size() == 2) chk("b2b.gap", 32'(done_t[1] - done_t[0]), 32'(FL + 1));

    // data change and valid pulses mid-frame are ignored
    done_t.delete();
    send(8'h96, "ign");
    for (int i = 0; i < FL + 4; i++) begin
      bus.data = 8'($urandom);
      bus.valid = (i % 23 == 7);
      step("ign");
    end
    bus.valid = 1'b0;
    for (int i = 0; i < 4; i++) step("ign");
    chk("ign.ndone", 32'(done_t.size()), 32'd1);

    // asynchronous reset during data bit 3
    done_t.delete();
    send(8'hC3, "rmid");
    for (int i = 0; i < 4 * OS + 5; i++) step("rmid");
    #2 nReset = 1'b0;
    m_act = 0; m_done = 0;
    #1 check_outs("rmid.async");
    #2;
    for (int i = 0; i < 3; i++) step("rmid.hold");
    #2 nReset = 1'b1;
    #1;
    for (int i = 0; i < FL; i++) step("rmid.after");
    chk("rmid.ndone", 32'(done_t.size()), 32'd0);
    send(8'h3C, "3c");
    for (int i = 0; i < FL + 4; i++) step("3c");
    chk("3c.ndone", 32'(done_t.size()), 32'd1);

    // randomized bytes with random valid patterns
    done_t.delete();
    for (int n = 0; n < 12; n++) begin
      bus.data = 8'($urandom);
      bus.valid = 1'b1;
      for (int i = 0; i < int'($urandom_range(1, FL + 3)); i++) begin
        step("rnd");
        if ($urandom_range(0, 3) == 0) bus.data = 8'($urandom);
      end
      bus.valid = 1'b0;
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) step("rnd");
    end
    for (int i = 0; i < 3 * FL; i++) step("rnd.drain");
    chk("rnd.idle", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
